// File: rtl/vga_text_pkg.sv
// vga_text_pkg: constants and types shared by the text-mode display path
// (renderer, timing generator, screen RAM and font ROM wrappers).
//   - 640x480@60 default timing, 80x60 cell grid, address widths
//   - pix_ctl_t: per-pixel control word carried down the fetch pipeline
//   - cell_addr(): row*80+col built from shifts and one adder chain
package vga_text_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_BLINK_BIT = 4;

    localparam int COLS        = 80;
    localparam int ROWS        = 60;
    localparam int CELLS       = COLS * ROWS;
    localparam int SCR_ADDR_W  = 13;
    localparam int FONT_ADDR_W = 11;
    localparam int CNT_W       = 10;
    localparam int RGB_W       = 12;
    localparam int FRAME_CNT_W = 6;

    typedef struct packed {
        logic             act;   // pixel lies in the visible area
        logic             hit;   // pixel belongs to the cursor cell
        logic             hs_n;  // raw horizontal sync
        logic             vs_n;  // raw vertical sync
        logic [2:0]       px;    // pixel position inside the 8-wide cell
        logic [RGB_W-1:0] fg;
        logic [RGB_W-1:0] bg;
    } pix_ctl_t;

    // Syncs idle high so the blanked pipeline never emits a false sync pulse.
    localparam pix_ctl_t PIX_CTL_RST = '{act: 1'b0, hit: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                                         px: 3'd0, fg: '0, bg: '0};

    // row*80 + col == (row<<6) + (row<<4) + col
    function automatic logic [SCR_ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                        input logic [6:0] col);
        logic [SCR_ADDR_W-1:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {6'd0, col};
    endfunction

endpackage

// File: rtl/vga_text_renderer_timing.sv
// vga_timing: free-running pixel/line counters for the display path.
// Ports:
//   clk, rst_n     pixel clock, async active-low reset
//   h_cnt_o        horizontal position 0..H_TOTAL-1
//   v_cnt_o        vertical position 0..V_TOTAL-1
//   active_o       visible-area flag for the current counter state
//   hsync_n_o      raw horizontal sync (not yet aligned with pixel data)
//   vsync_n_o      raw vertical sync
//   frame_tick_o   high on the last pixel of the frame
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             active_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o,
    output logic             frame_tick_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_wrap, v_wrap;

    always_comb begin
        h_wrap = (h_q == CNT_W'(H_TOTAL - 1));
        v_wrap = (v_q == CNT_W'(V_TOTAL - 1));
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o      = h_q;
    assign v_cnt_o      = v_q;
    assign active_o     = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
    assign hsync_n_o    = !((h_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                            (h_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_n_o    = !((v_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                            (v_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    assign frame_tick_o = h_wrap && v_wrap;

endmodule

// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x60 text-mode VGA front end.
// Pipeline: stage 0 counters + screen RAM address, stage 1 font ROM address,
// stage 2 glyph bit select, stage 3 output register (3 clk counter->pin).
// Ports:
//   clk, rst_n              pixel clock, async active-low reset
//   scr_addr / scr_data     screen RAM read port (1-cycle registered read)
//   font_addr / font_data   font ROM read port {char,row}, bit 7 = leftmost
//   fg_color / bg_color     RGB444 colours, sampled with the pixel at stage 0
//   cursor_en / cursor_addr blinking inverse-video cursor cell
//   hsync_n, vsync_n, de    aligned syncs and data enable
//   rgb                     pixel colour, forced to 0 while blanked
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int BLINK_BIT = DEF_BLINK_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [SCR_ADDR_W-1:0]  scr_addr,
    input  logic [7:0]             scr_data,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [7:0]             font_data,
    input  logic [RGB_W-1:0]       fg_color,
    input  logic [RGB_W-1:0]       bg_color,
    input  logic                   cursor_en,
    input  logic [SCR_ADDR_W-1:0]  cursor_addr,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic                   de,
    output logic [RGB_W-1:0]       rgb
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active0, hs0_n, vs0_n, frame_tick;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active0),
        .hsync_n_o   (hs0_n),
        .vsync_n_o   (vs0_n),
        .frame_tick_o(frame_tick)
    );

    // Top line bit only matters in blanking, where the address is forced to 0.
    logic unused_v_msb;
    assign unused_v_msb = v_cnt[CNT_W-1];

    // ---- stage 0 ----
    logic [SCR_ADDR_W-1:0] addr0;
    pix_ctl_t              st0;

    always_comb begin
        addr0 = '0;
        if (active0) addr0 = cell_addr(v_cnt[8:3], h_cnt[9:3]);
        // addr0 never exceeds CELLS-1, so out-of-range cursor values never hit.
        st0 = '{act:  active0,
                hit:  cursor_en && active0 && (addr0 == cursor_addr),
                hs_n: hs0_n,
                vs_n: vs0_n,
                px:   h_cnt[2:0],
                fg:   fg_color,
                bg:   bg_color};
    end

    assign scr_addr = addr0;

    // ---- stages 1 and 2 ----
    pix_ctl_t                st1_q, st2_q;
    logic [2:0]              gly1_q;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_q       <= PIX_CTL_RST;
            st2_q       <= PIX_CTL_RST;
            gly1_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            st1_q       <= st0;
            gly1_q      <= v_cnt[2:0];
            st2_q       <= st1_q;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(frame_tick);
        end
    end

    // Gated by the stage-1 active flag so the ROM address is quiet (and 0
    // out of reset) whenever the RAM data is not a real character.
    assign font_addr = st1_q.act ? {scr_data, gly1_q} : '0;

    // ---- stage 3: output register ----
    logic             pix;
    logic [RGB_W-1:0] rgb_d, rgb_q;
    logic             de_q, hs_q, vs_q;

    always_comb begin
        pix   = font_data[3'd7 - st2_q.px] ^ (st2_q.hit && frame_cnt_q[BLINK_BIT]);
        rgb_d = '0;
        if (st2_q.act) rgb_d = pix ? st2_q.fg : st2_q.bg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= st2_q.act;
            hs_q  <= st2_q.hs_n;
            vs_q  <= st2_q.vs_n;
        end
    end

    assign rgb     = rgb_q;
    assign de      = de_q;
    assign hsync_n = hs_q;
    assign vsync_n = vs_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer on a shrunken raster
// (48 clk lines, 22-line frames) so several frames fit in a short run.
module tb_vga_text_renderer;

    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 48
    localparam int VT = VA + VF + VS + VB;   // 22
    localparam int FT = HT * VT;             // 1056

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] scr_addr;
    logic [7:0]  scr_data = 8'h00;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic [11:0] fg_color, bg_color;
    logic        cursor_en;
    logic [12:0] cursor_addr;
    logic        hsync_n, vsync_n, de;
    logic [11:0] rgb;

    vga_text_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BLINK_BIT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .scr_addr(scr_addr), .scr_data(scr_data),
        .font_addr(font_addr), .font_data(font_data),
        .fg_color(fg_color), .bg_color(bg_color),
        .cursor_en(cursor_en), .cursor_addr(cursor_addr),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // 1-cycle registered RAM/ROM models
    logic [7:0] scr_mem  [0:8191];
    logic [7:0] font_mem [0:2047];
    always @(posedge clk) begin
        scr_data  <= scr_mem[scr_addr];
        font_data <= font_mem[font_addr];
    end

    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // sync/de measurement, updated once per clock
    int   hs_fall = -1, hs_per = 0, hs_low = 0;
    int   vs_fall = -1, vs_per = 0, vs_low = 0;
    int   de_cnt = 0, de_frame = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (hs_prev && !hsync_n) begin
            if (hs_fall >= 0) hs_per = cyc - hs_fall;
            hs_fall = cyc;
        end
        if (!hs_prev && hsync_n) hs_low = cyc - hs_fall;
        if (vs_prev && !vsync_n) begin
            if (vs_fall >= 0) vs_per = cyc - vs_fall;
            vs_fall  = cyc;
            de_frame = de_cnt;
            de_cnt   = 0;
        end
        if (!vs_prev && vsync_n) vs_low = cyc - vs_fall;
        if (de) de_cnt++;
        hs_prev = hsync_n;
        vs_prev = vsync_n;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    // cycle (after release) at which pixel (frame,v,h) is on the outputs
    function automatic int pixc(input int f, input int v, input int h);
        return f * FT + v * HT + h + 3;
    endfunction

    logic [11:0] exp_px [8];

    initial begin
        for (int i = 0; i < 8192; i++) scr_mem[i] = 8'h00;
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
        scr_mem[0] = 8'h41;
        for (int r = 0; r < 8; r++) font_mem[8'h41 * 8 + r] = 8'h18;
        font_mem[8'h41 * 8 + 1] = 8'h81;
        exp_px = '{12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000};

        fg_color = 12'hFFF; bg_color = 12'h000;
        cursor_en = 1'b0; cursor_addr = 13'd0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_hsync", hsync_n, 1);
        chk("rst_vsync", vsync_n, 1);
        chk("rst_de", de, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_scr_addr", scr_addr, 0);
        chk("rst_font_addr", font_addr, 0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; de_cnt = 0;

        goto(2);  chk("de_fill", de, 0);
        goto(3);  chk("de_first", de, 1);
        for (int i = 0; i < 8; i++) begin
            goto(3 + i);
            chk($sformatf("cell0_px%0d", i), rgb, exp_px[i]);
        end
        goto(24); chk("addr_col3", scr_addr, 3);
        goto(30); bg_color = 12'h0A5;
        goto(35);
        chk("blank_rgb", rgb, 0);
        chk("blank_de", de, 0);
        chk("blank_addr", scr_addr, 0);
        goto(pixc(0, 1, 0)); chk("glyph_row1_px0", rgb, 12'hFFF);
        goto(pixc(0, 1, 1)); chk("glyph_row1_px1", rgb, 12'h0A5);
        goto(744); chk("addr_last_cell", scr_addr, 83);
        goto(760); cursor_en = 1'b1; cursor_addr = 13'd81;

        goto(pixc(1, 8, 8)); chk("cursor_f1", rgb, 12'h0A5);
        goto(pixc(2, 0, 0));
        chk("hs_period", hs_per, HT);
        chk("hs_low", hs_low, HS);
        chk("vs_period", vs_per, FT);
        chk("vs_low", vs_low, VS * HT);
        chk("de_per_frame", de_frame, HA * VA);
        goto(pixc(2, 8, 8));  chk("cursor_f2", rgb, 12'hFFF);
        goto(pixc(2, 8, 16)); chk("cursor_neighbour", rgb, 12'h0A5);
        goto(pixc(3, 8, 8));  chk("cursor_f3", rgb, 12'hFFF);
        goto(pixc(4, 8, 8));  chk("cursor_f4", rgb, 12'h0A5);
        goto(pixc(5, 0, 0));  cursor_addr = 13'd4800;
        goto(pixc(6, 8, 8));  chk("cursor_oob", rgb, 12'h0A5);

        goto(pixc(6, 10, 17));
        chk("pre_rst_de", de, 1);
        chk("pre_rst_rgb", rgb, 12'h0A5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_hsync", hsync_n, 1);
        chk("mid_rst_vsync", vsync_n, 1);
        chk("mid_rst_de", de, 0);
        chk("mid_rst_rgb", rgb, 0);
        chk("mid_rst_scr_addr", scr_addr, 0);
        chk("mid_rst_font_addr", font_addr, 0);
        repeat (5) tick();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (hsync_n && cyc < 200) tick();
        chk("hs_fall_after_rst", cyc, HA + HF + 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
